// File: rtl/bcd_scan_display_if.sv
// Digit-input and display-output bundle for bcd_scan_display.
// master = digit source / display observer, slave = the scan driver.
interface bcd_scan_display_if;
  logic       load;
  logic [3:0] ones;
  logic [3:0] tens;
  logic [3:0] hundreds;
  logic [3:0] thousands;
  logic [6:0] seg;
  logic [3:0] an;
  logic       frame_done;

  modport master (
    output load, ones, tens, hundreds, thousands,
    input  seg, an, frame_done
  );

  modport slave (
    input  load, ones, tens, hundreds, thousands,
    output seg, an, frame_done
  );
endinterface

// File: rtl/bcd_scan_display.sv
// Multiplexed 4-digit common-anode seven-segment driver with a shadow/active bank.
// The shadow bank commits to the active bank only at frame boundaries.
// Define LEADING_ZERO_BLANK_EN to suppress leading zeros.
module bcd_scan_display #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  bcd_scan_display_if.slave   bus
);

  localparam int             PW     = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0]  P_LAST = PW'(REFRESH_DIV - 1);

  logic [PW-1:0]      p_q, p_d;
  logic [1:0]         d_q, d_d;
  logic [3:0][3:0]    shadow_q, shadow_d;
  logic [3:0][3:0]    active_q, active_d;
  logic               pending_q, pending_d;
  logic [6:0]         seg_q, seg_d;
  logic [3:0]         an_q, an_d;
  logic               frame_done_q, frame_done_d;

  logic               slot_end;
  logic               boundary;
  logic               in_blank;
  logic [3:0]         lz_blank;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  assign slot_end = (p_q == P_LAST);
  assign boundary = slot_end && (d_q == 2'd3);

  // Next scan position and bank state; the commit reads the pre-load shadow.
  always_comb begin
    p_d          = p_q + PW'(1);
    d_d          = d_q;
    shadow_d     = shadow_q;
    active_d     = active_q;
    pending_d    = pending_q;
    frame_done_d = boundary;
    if (slot_end) begin
      p_d = '0;
      d_d = d_q + 2'd1;
    end
    if (boundary && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    if (bus.load) begin
      shadow_d  = {bus.thousands, bus.hundreds, bus.tens, bus.ones};
      pending_d = 1'b1;
    end
  end

  generate
    if (BLANK_CYCLES == 0) begin : g_no_blank
      assign in_blank = 1'b0;
    end else begin : g_blank
      assign in_blank = (p_d < PW'(BLANK_CYCLES));
    end
  endgenerate

`ifdef LEADING_ZERO_BLANK_EN
  logic [3:0] zero_digit;
  for (genvar gi = 0; gi < 4; gi++) begin : g_zero
    assign zero_digit[gi] = (active_d[gi] == 4'd0);
  end
  // A digit is a leading zero only if it and every digit to its left are zero.
  assign lz_blank[3] = zero_digit[3];
  assign lz_blank[2] = zero_digit[3] & zero_digit[2];
  assign lz_blank[1] = zero_digit[3] & zero_digit[2] & zero_digit[1];
  assign lz_blank[0] = 1'b0;
`else
  assign lz_blank = 4'b0000;
`endif

  // Outputs are computed from next state so they track p/d/bank with no lag.
  always_comb begin
    seg_d = seg_decode(active_d[d_d]);
    an_d  = 4'b1111;
    if (!in_blank && !lz_blank[d_d]) begin
      an_d = ~(4'b0001 << d_d);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p_q          <= '0;
      d_q          <= 2'd0;
      shadow_q     <= '0;
      active_q     <= '0;
      pending_q    <= 1'b0;
      seg_q        <= 7'b1000000;
      an_q         <= 4'b1111;
      frame_done_q <= 1'b0;
    end else begin
      p_q          <= p_d;
      d_q          <= d_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.an         = an_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Directed bench for bcd_scan_display with REFRESH_DIV=4, BLANK_CYCLES=1.
// Each frame is 16 cycles; cyc counts cycles since the last reset release.
module tb_bcd_scan_display;
  logic clk;
  logic reset;
  int   compared;
  int   mismatched;
  int   cyc;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  bcd_scan_display_if dif ();

  bcd_scan_display #(
    .REFRESH_DIV  (4),
    .BLANK_CYCLES (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto(input int c);
    while (cyc < c) tick();
  endtask

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_seg(input string tag, input logic [6:0] exp);
    check(tag, dif.seg, exp);
  endtask

  task automatic chk_an(input string tag, input logic [3:0] exp);
    check(tag, {3'b000, dif.an}, {3'b000, exp});
  endtask

  task automatic chk_fd(input string tag, input logic exp);
    check(tag, {6'b000000, dif.frame_done}, {6'b000000, exp});
  endtask

  task automatic do_load(input logic [3:0] th, input logic [3:0] hu,
                         input logic [3:0] te, input logic [3:0] on);
    $display("load %h%h%h%h at cyc %0d", th, hu, te, on, cyc);
    dif.thousands = th;
    dif.hundreds  = hu;
    dif.tens      = te;
    dif.ones      = on;
    dif.load      = 1'b1;
    tick();
    dif.load      = 1'b0;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    cyc        = 0;
    reset      = 1'b1;
    dif.load   = 1'b0;
    dif.ones   = 4'd0;
    dif.tens   = 4'd0;
    dif.hundreds  = 4'd0;
    dif.thousands = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    cyc   = 0;

    // Reset release, no load
    chk_an ("rst_an", 4'b1111);
    chk_seg("rst_seg", 7'b1000000);
    chk_fd ("rst_fd", 1'b0);
    goto(1);  chk_an("c1_an", 4'b1110);
    goto(3);  chk_an("c3_an", 4'b1110);
    goto(4);  chk_an("c4_an", 4'b1111);
    goto(5);  chk_an("c5_an", LZB ? 4'b1111 : 4'b1101);
    goto(15); chk_fd("fd_c15", 1'b0);
    goto(16); chk_fd("fd_c16", 1'b1);
    chk_seg("c16_seg", 7'b1000000);
    goto(17); chk_fd("fd_c17", 1'b0);

    // Mid-frame load of 1234 commits at cyc 32
    goto(20); do_load(4'd1, 4'd2, 4'd3, 4'd4);
    goto(25); chk_seg("hold_s2", 7'b1000000);
    goto(29); chk_seg("hold_s3", 7'b1000000);
    goto(31); chk_fd("pre_commit_fd", 1'b0);
    goto(32); chk_fd("commit_fd", 1'b1);
    chk_seg("commit_d0", 7'b0011001);
    chk_an ("commit_blank", 4'b1111);
    goto(33); chk_an("d0_an", 4'b1110);
    goto(37); chk_seg("d1_seg", 7'b0110000);
    chk_an ("d1_an", 4'b1101);
    goto(41); chk_seg("d2_seg", 7'b0100100);
    goto(45); chk_seg("d3_seg", 7'b1111001);
    chk_an ("d3_an", 4'b0111);

    // 5555 pending, then 9876 loaded on the boundary edge 63->64
    goto(50); do_load(4'd5, 4'd5, 4'd5, 4'd5);
    goto(63); do_load(4'd9, 4'd8, 4'd7, 4'd6);
    chk_fd ("bnd_fd", 1'b1);
    chk_seg("bnd_d0", 7'b0010010);
    goto(69); chk_seg("bnd_d1", 7'b0010010);
    goto(77); chk_seg("bnd_d3", 7'b0010010);
    goto(80); chk_fd("nxt_fd", 1'b1);
    chk_seg("nxt_d0", 7'b0000010);
    goto(85); chk_seg("nxt_d1", 7'b1111000);
    goto(89); chk_seg("nxt_d2", 7'b0000000);
    goto(93); chk_seg("nxt_d3", 7'b0010000);
    chk_an ("nxt_d3_an", 4'b0111);

    // Non-BCD code on ones shows a dash
    goto(100); do_load(4'd1, 4'd0, 4'd0, 4'hC);
    goto(112); chk_seg("dash_d0", 7'b0111111);
    goto(113); chk_an("dash_an", 4'b1110);
    goto(121); chk_seg("mid0_seg", 7'b1000000);
    chk_an ("mid0_an", 4'b1011);

    // Leading zeros: 0042
    goto(130); do_load(4'd0, 4'd0, 4'd4, 4'd2);
    goto(145); chk_seg("lz_d0", 7'b0100100);
    chk_an ("lz_d0_an", 4'b1110);
    goto(149); chk_seg("lz_d1", 7'b0011001);
    chk_an ("lz_d1_an", 4'b1101);
    goto(153); chk_seg("lz_d2", 7'b1000000);
    chk_an ("lz_d2_an", LZB ? 4'b1111 : 4'b1011);
    goto(157); chk_seg("lz_d3", 7'b1000000);
    chk_an ("lz_d3_an", LZB ? 4'b1111 : 4'b0111);

    // Reset during slot 2 with 7777 pending
    goto(162); do_load(4'd7, 4'd7, 4'd7, 4'd7);
    goto(169);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cyc   = 0;
    chk_an ("mrst_an", 4'b1111);
    chk_seg("mrst_seg", 7'b1000000);
    chk_fd ("mrst_fd", 1'b0);
    goto(1);  chk_an("mrst_c1_an", 4'b1110);
    goto(16); chk_fd("mrst_fd16", 1'b1);
    chk_seg("mrst_seg16", 7'b1000000);
    goto(17); chk_an("mrst_an17", 4'b1110);
    goto(29); chk_seg("mrst_d3", 7'b1000000);
    goto(33); chk_seg("mrst_seg33", 7'b1000000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
